// File: rtl/csr_trap_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// csr_trap_sequencer_pkg
// Shared types, CSR slot map and helper functions for the trap sequencer.
//  - trap_seq_state_t : sequencer FSM states (IDLE, COMMIT, REDIRECT)
//  - trap_kind_t      : latched request kind (TRAP, MRET)
//  - CSR_* indices    : slot of each CSR in the csr_values / write arrays
//  - mstatus_on_trap / mstatus_on_mret / trap_target : update helpers
// Optional feature macro: CSR_COUNTERS_EN (mcycle/minstret slots only used then)
// -----------------------------------------------------------------------------
package csr_trap_sequencer_pkg;

  localparam int XLEN      = 32;
  localparam int CSR_COUNT = 7;
  localparam int CSR_IDX_W = $clog2(CSR_COUNT);
  localparam int CSR_SLOTS = 2 ** CSR_IDX_W;

  // Slot map of the CSR read file (validCSRs order)
  localparam int CSR_MSTATUS  = 0;
  localparam int CSR_MTVEC    = 1;
  localparam int CSR_MEPC     = 2;
  localparam int CSR_MCAUSE   = 3;
  localparam int CSR_MTVAL    = 4;
  localparam int CSR_MCYCLE   = 5;
  localparam int CSR_MINSTRET = 6;

  localparam int MSTATUS_MIE     = 3;
  localparam int MSTATUS_MPIE    = 7;
  localparam int MSTATUS_MPP_LSB = 11;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COMMIT   = 2'b01,
    REDIRECT = 2'b10
  } trap_seq_state_t;

  typedef enum logic {
    TRAP = 1'b0,
    MRET = 1'b1
  } trap_kind_t;

  // Trap entry: stack MIE into MPIE, disable interrupts, record previous mode.
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] mstatus,
                                                      input logic [1:0]      mpp);
    logic [XLEN-1:0] v;
    v                         = mstatus;
    v[MSTATUS_MPIE]           = mstatus[MSTATUS_MIE];
    v[MSTATUS_MIE]            = 1'b0;
    v[MSTATUS_MPP_LSB +: 2]   = mpp;
    return v;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE.
  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] mstatus,
                                                      input logic [1:0]      mpp);
    logic [XLEN-1:0] v;
    v                         = mstatus;
    v[MSTATUS_MIE]            = mstatus[MSTATUS_MPIE];
    v[MSTATUS_MPIE]           = 1'b1;
    v[MSTATUS_MPP_LSB +: 2]   = mpp;
    return v;
  endfunction

  // Trap vector: BASE, or BASE + 4*cause for interrupts in vectored mode.
  // The cause shift drops bit XLEN-2, giving the required mod 2**XLEN wrap.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input logic [XLEN-1:0] cause,
                                                  input logic            vectored_en);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (vectored_en && (mtvec[1:0] == MTVEC_MODE_VECTORED) && cause[XLEN-1]) begin
      return base + {cause[XLEN-3:0], 2'b00};
    end else begin
      return base;
    end
  endfunction

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// -----------------------------------------------------------------------------
// csr_trap_sequencer_if
// Request / redirect bundle between writeback, fetch and the trap sequencer.
//  master : writeback + fetch side (drives requests, redirect_ready)
//  slave  : trap sequencer (drives busy, flush_req, redirect_valid/pc)
// -----------------------------------------------------------------------------
interface csr_trap_sequencer_if;
  import csr_trap_sequencer_pkg::*;

  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_val;
  logic            mret_req;
  logic            retire_valid;
  logic            busy;
  logic            flush_req;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output trap_req, trap_cause, trap_pc, trap_val, mret_req, retire_valid, redirect_ready,
    input  busy, flush_req, redirect_valid, redirect_pc
  );

  modport slave (
    input  trap_req, trap_cause, trap_pc, trap_val, mret_req, retire_valid, redirect_ready,
    output busy, flush_req, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/csr_trap_sequencer_counter_bank.sv
// -----------------------------------------------------------------------------
// csr_counter_bank
// Increment logic for mcycle (every cycle) and minstret (on retire).
// Used only when CSR_COUNTERS_EN is defined.
// Ports:
//  i_enable        : low while the sequencer is held in reset
//  i_retire_valid  : one instruction retired this cycle
//  i_mcycle/i_minstret : current counter values from the CSR read file
//  o_*_we / o_*_wd : hardware write enable / data for each counter
// -----------------------------------------------------------------------------
module csr_counter_bank
  import csr_trap_sequencer_pkg::*;
(
  input  logic            i_enable,
  input  logic            i_retire_valid,
  input  logic [XLEN-1:0] i_mcycle,
  input  logic [XLEN-1:0] i_minstret,
  output logic            o_mcycle_we,
  output logic [XLEN-1:0] o_mcycle_wd,
  output logic            o_minstret_we,
  output logic [XLEN-1:0] o_minstret_wd
);

  logic w_minstret_we;

  assign w_minstret_we = i_enable & i_retire_valid;

  // Counters wrap naturally at 2**XLEN; data is zeroed when not written.
  assign o_mcycle_we   = i_enable;
  assign o_mcycle_wd   = i_enable ? (i_mcycle + {{(XLEN-1){1'b0}}, 1'b1}) : '0;
  assign o_minstret_we = w_minstret_we;
  assign o_minstret_wd = w_minstret_we ? (i_minstret + {{(XLEN-1){1'b0}}, 1'b1}) : '0;

endmodule

// File: rtl/csr_trap_sequencer.sv
// -----------------------------------------------------------------------------
// csr_trap_sequencer
// Turns trap / MRET events from writeback into one atomic cycle of CSR
// hardware writes (mepc, mcause, mtval, mstatus), then offers a PC redirect
// to fetch over a valid/ready handshake. FSM: IDLE -> COMMIT -> REDIRECT.
// Optional feature macro: CSR_COUNTERS_EN (mcycle / minstret increment).
// Ports:
//  clk, rst_n              : clock, asynchronous active-low reset
//  i_srst                  : synchronous soft reset (same effect as rst_n)
//  seq_if (slave)          : trap/MRET requests, busy, flush, redirect handshake
//  i_csr_values            : current CSR contents, one XLEN slot per CSR
//  o_internal_write_en     : per-CSR hardware write enable
//  o_internal_write_data   : per-CSR hardware write data (0 when not enabled)
// Parameters:
//  MPP_MODE         : privilege written to mstatus.MPP
//  VECTORED_SUPPORT : 1 lets mtvec.MODE=01 vector interrupts
// -----------------------------------------------------------------------------
module csr_trap_sequencer
  import csr_trap_sequencer_pkg::*;
#(
  parameter logic [1:0] MPP_MODE         = 2'b11,
  parameter bit         VECTORED_SUPPORT = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_srst,
  csr_trap_sequencer_if.slave              seq_if,
  input  logic [CSR_SLOTS-1:0][XLEN-1:0]   i_csr_values,
  output logic [CSR_SLOTS-1:0]             o_internal_write_en,
  output logic [CSR_SLOTS-1:0][XLEN-1:0]   o_internal_write_data
);

  trap_seq_state_t r_state;
  trap_seq_state_t w_next_state;
  trap_kind_t      r_kind;
  trap_kind_t      w_accept_kind;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_val;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_run;
  logic            w_accept;
  logic [XLEN-1:0] w_redirect_target;
  logic [CSR_SLOTS-1:0]           w_we;
  logic [CSR_SLOTS-1:0][XLEN-1:0] w_wd;
  logic            w_unused_csr;

  // Only a few slots are read here; fold the rest so nothing dangles.
  assign w_unused_csr = ^i_csr_values;

  // State register, request latch and redirect target register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_kind        <= TRAP;
      r_cause       <= '0;
      r_pc          <= '0;
      r_val         <= '0;
      r_redirect_pc <= '0;
      r_run         <= 1'b0;
    end else if (i_srst) begin
      r_state       <= IDLE;
      r_kind        <= TRAP;
      r_cause       <= '0;
      r_pc          <= '0;
      r_val         <= '0;
      r_redirect_pc <= '0;
      r_run         <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
      if (w_accept) begin
        r_kind  <= w_accept_kind;
        r_cause <= seq_if.trap_cause;
        r_pc    <= seq_if.trap_pc;
        r_val   <= seq_if.trap_val;
      end
      // Captured at the end of COMMIT so it is stable through REDIRECT.
      if (r_state == COMMIT) begin
        r_redirect_pc <= w_redirect_target;
      end
    end
  end

  // Next-state logic; requests are only looked at in IDLE, trap beats MRET.
  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_accept_kind = seq_if.trap_req ? TRAP : MRET;
    case (r_state)
      IDLE: begin
        if (seq_if.trap_req || seq_if.mret_req) begin
          w_accept     = 1'b1;
          w_next_state = COMMIT;
        end else begin
          w_next_state = IDLE;
        end
      end
      COMMIT: begin
        w_next_state = REDIRECT;
      end
      REDIRECT: begin
        if (seq_if.redirect_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = REDIRECT;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Redirect target: trap vector for traps, live mepc for MRET.
  always_comb begin
    w_redirect_target = '0;
    if (r_kind == TRAP) begin
      w_redirect_target = trap_target(i_csr_values[CSR_MTVEC], r_cause, VECTORED_SUPPORT);
    end else begin
      w_redirect_target = i_csr_values[CSR_MEPC];
    end
  end

`ifdef CSR_COUNTERS_EN
  logic            w_mcycle_we;
  logic [XLEN-1:0] w_mcycle_wd;
  logic            w_minstret_we;
  logic [XLEN-1:0] w_minstret_wd;

  csr_counter_bank u_counter_bank (
    .i_enable       (r_run),
    .i_retire_valid (seq_if.retire_valid),
    .i_mcycle       (i_csr_values[CSR_MCYCLE]),
    .i_minstret     (i_csr_values[CSR_MINSTRET]),
    .o_mcycle_we    (w_mcycle_we),
    .o_mcycle_wd    (w_mcycle_wd),
    .o_minstret_we  (w_minstret_we),
    .o_minstret_wd  (w_minstret_wd)
  );
`else
  logic w_unused_retire;
  logic w_unused_run;
  assign w_unused_retire = seq_if.retire_valid;
  assign w_unused_run    = r_run;
`endif

  // Hardware CSR writes: trap/MRET updates in COMMIT, counters when enabled.
  always_comb begin
    w_we = '0;
    w_wd = '0;
    if (r_state == COMMIT) begin
      if (r_kind == TRAP) begin
        w_we[CSR_MEPC]    = 1'b1;
        w_wd[CSR_MEPC]    = {r_pc[XLEN-1:2], 2'b00};
        w_we[CSR_MCAUSE]  = 1'b1;
        w_wd[CSR_MCAUSE]  = r_cause;
        w_we[CSR_MTVAL]   = 1'b1;
        w_wd[CSR_MTVAL]   = r_val;
        w_we[CSR_MSTATUS] = 1'b1;
        w_wd[CSR_MSTATUS] = mstatus_on_trap(i_csr_values[CSR_MSTATUS], MPP_MODE);
      end else begin
        w_we[CSR_MSTATUS] = 1'b1;
        w_wd[CSR_MSTATUS] = mstatus_on_mret(i_csr_values[CSR_MSTATUS], MPP_MODE);
      end
    end else begin
      w_we = '0;
    end
`ifdef CSR_COUNTERS_EN
    w_we[CSR_MCYCLE]   = w_mcycle_we;
    w_wd[CSR_MCYCLE]   = w_mcycle_wd;
    w_we[CSR_MINSTRET] = w_minstret_we;
    w_wd[CSR_MINSTRET] = w_minstret_wd;
`endif
  end

  assign o_internal_write_en   = w_we;
  assign o_internal_write_data = w_wd;

  assign seq_if.busy           = (r_state != IDLE);
  assign seq_if.flush_req      = (r_state == COMMIT);
  assign seq_if.redirect_valid = (r_state == REDIRECT);
  assign seq_if.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_sequencer
// Directed bench for csr_trap_sequencer. The bench plays the CSR read file:
// it stores DUT hardware writes plus its own host writes, and feeds the
// contents back as i_csr_values. A second instance with VECTORED_SUPPORT=0
// shares the stimulus for the non-vectored redirect case.
// Build with CSR_COUNTERS_EN defined to exercise the counter bank.
// -----------------------------------------------------------------------------
module tb_csr_trap_sequencer;
  import csr_trap_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic srst;

  csr_trap_sequencer_if seq_if ();
  csr_trap_sequencer_if nv_if ();

  logic [CSR_SLOTS-1:0][XLEN-1:0] csr_file;
  logic [CSR_SLOTS-1:0]           we;
  logic [CSR_SLOTS-1:0][XLEN-1:0] wd;
  logic [CSR_SLOTS-1:0]           nv_unused_we;
  logic [CSR_SLOTS-1:0][XLEN-1:0] nv_unused_wd;

  logic                 host_we;
  logic [CSR_IDX_W-1:0] host_idx;
  logic [XLEN-1:0]      host_data;

  int n_checks = 0;
  int n_errors = 0;

  csr_trap_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_srst                (srst),
    .seq_if                (seq_if.slave),
    .i_csr_values          (csr_file),
    .o_internal_write_en   (we),
    .o_internal_write_data (wd)
  );

  csr_trap_sequencer #(.VECTORED_SUPPORT(1'b0)) dut_nv (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_srst                (srst),
    .seq_if                (nv_if.slave),
    .i_csr_values          (csr_file),
    .o_internal_write_en   (nv_unused_we),
    .o_internal_write_data (nv_unused_wd)
  );

  assign nv_if.trap_req       = seq_if.trap_req;
  assign nv_if.trap_cause     = seq_if.trap_cause;
  assign nv_if.trap_pc        = seq_if.trap_pc;
  assign nv_if.trap_val       = seq_if.trap_val;
  assign nv_if.mret_req       = seq_if.mret_req;
  assign nv_if.retire_valid   = seq_if.retire_valid;
  assign nv_if.redirect_ready = seq_if.redirect_ready;

  // CSR read file model: DUT hardware writes, host writes take priority.
  always @(posedge clk) begin
    if (!rst_n) begin
      csr_file <= '0;
    end else begin
      for (int i = 0; i < CSR_SLOTS; i++) begin
        if (we[i]) csr_file[i] <= wd[i];
      end
      if (host_we) csr_file[host_idx] <= host_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int idx, input logic [XLEN-1:0] data);
    host_we   = 1'b1;
    host_idx  = idx[CSR_IDX_W-1:0];
    host_data = data;
    tick();
    host_we   = 1'b0;
  endtask

  task automatic present_trap(input logic [XLEN-1:0] cause, input logic [XLEN-1:0] pc,
                              input logic [XLEN-1:0] val);
    seq_if.trap_req   = 1'b1;
    seq_if.trap_cause = cause;
    seq_if.trap_pc    = pc;
    seq_if.trap_val   = val;
  endtask

  task automatic finish_redirect();
    seq_if.redirect_ready = 1'b1;
    tick();
    seq_if.redirect_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    srst  = 1'b0;
    host_we = 1'b0; host_idx = '0; host_data = '0;
    seq_if.trap_req = 1'b0; seq_if.trap_cause = '0; seq_if.trap_pc = '0;
    seq_if.trap_val = '0; seq_if.mret_req = 1'b0; seq_if.retire_valid = 1'b0;
    seq_if.redirect_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_busy",  32'(seq_if.busy), 32'h0);
    check_value("rst_valid", 32'(seq_if.redirect_valid), 32'h0);
    check_value("rst_flush", 32'(seq_if.flush_req), 32'h0);
    check_value("rst_we",    32'(we), 32'h0);
    rst_n = 1'b1;
    tick();

`ifdef CSR_COUNTERS_EN
    // Counters: wrap of mcycle, 10 cycles with 4 retires
    host_write(CSR_MINSTRET, 32'h0000_0100);
    host_write(CSR_MCYCLE, 32'hFFFF_FFFF);
    check_value("mcycle_we",   32'(we[CSR_MCYCLE]), 32'h1);
    check_value("mcycle_wrap", wd[CSR_MCYCLE], 32'h0);
    for (int i = 0; i < 10; i++) begin
      seq_if.retire_valid = (i < 8) && (i % 2 == 0);
      tick();
    end
    seq_if.retire_valid = 1'b0;
    check_value("mcycle_plus10",  csr_file[CSR_MCYCLE], 32'h0000_0009);
    check_value("minstret_plus4", csr_file[CSR_MINSTRET], 32'h0000_0104);
`else
    seq_if.retire_valid = 1'b1;
    tick();
    seq_if.retire_valid = 1'b0;
    check_value("no_cnt_we",   32'(we[CSR_MCYCLE] | we[CSR_MINSTRET]), 32'h0);
    check_value("no_cnt_data", wd[CSR_MINSTRET], 32'h0);
`endif

    // Synchronous trap
    host_write(CSR_MTVEC, 32'h8000_0100);
    host_write(CSR_MSTATUS, 32'h0000_0008);
    present_trap(32'h2, 32'h8000_0040, 32'h0000_DEAD);
    tick();
    seq_if.trap_req = 1'b0;
    check_value("t2_busy",     32'(seq_if.busy), 32'h1);
    check_value("t2_flush",    32'(seq_if.flush_req), 32'h1);
    check_value("t2_mepc_we",  32'(we[CSR_MEPC]), 32'h1);
    check_value("t2_mstat_wd", wd[CSR_MSTATUS], 32'h0000_1880);
    check_value("t2_mtvec_we", 32'(we[CSR_MTVEC]), 32'h0);
    check_value("t2_mtvec_wd", wd[CSR_MTVEC], 32'h0);
    tick();
    check_value("t2_mepc",   csr_file[CSR_MEPC], 32'h8000_0040);
    check_value("t2_mcause", csr_file[CSR_MCAUSE], 32'h0000_0002);
    check_value("t2_mtval",  csr_file[CSR_MTVAL], 32'h0000_DEAD);
    check_value("t2_mstat",  csr_file[CSR_MSTATUS], 32'h0000_1880);
    check_value("t2_flush_off", 32'(seq_if.flush_req), 32'h0);
    check_value("t2_valid",  32'(seq_if.redirect_valid), 32'h1);
    check_value("t2_rpc",    seq_if.redirect_pc, 32'h8000_0100);
    finish_redirect();
    check_value("t2_idle",   32'(seq_if.busy), 32'h0);
    check_value("t2_valid_off", 32'(seq_if.redirect_valid), 32'h0);

    // Vectored interrupt, misaligned PC
    host_write(CSR_MTVEC, 32'h8000_0101);
    present_trap(32'h8000_0007, 32'h8000_0047, 32'h0);
    tick();
    seq_if.trap_req = 1'b0;
    tick();
    check_value("t3_rpc_vec",   seq_if.redirect_pc, 32'h8000_011C);
    check_value("t3_rpc_novec", nv_if.redirect_pc, 32'h8000_0100);
    check_value("t3_mepc_align", csr_file[CSR_MEPC], 32'h8000_0044);
    check_value("t3_mstat",     csr_file[CSR_MSTATUS], 32'h0000_1800);
    finish_redirect();

    // MRET
    host_write(CSR_MSTATUS, 32'h0000_1880);
    seq_if.mret_req = 1'b1;
    tick();
    seq_if.mret_req = 1'b0;
    check_value("t4_mepc_we",   32'(we[CSR_MEPC]), 32'h0);
    check_value("t4_mcause_we", 32'(we[CSR_MCAUSE]), 32'h0);
    check_value("t4_mstat_we",  32'(we[CSR_MSTATUS]), 32'h1);
    tick();
    check_value("t4_mstat",  csr_file[CSR_MSTATUS], 32'h0000_1888);
    check_value("t4_mcause", csr_file[CSR_MCAUSE], 32'h8000_0007);
    check_value("t4_rpc",    seq_if.redirect_pc, 32'h8000_0044);
    finish_redirect();

    // Simultaneous trap + MRET, stalled redirect, ignored trap while busy
    host_write(CSR_MTVEC, 32'h8000_0200);
    present_trap(32'hB, 32'h8000_0100, 32'h5);
    seq_if.mret_req = 1'b1;
    tick();
    seq_if.trap_req = 1'b0;
    seq_if.mret_req = 1'b0;
    check_value("t5_mcause_we", 32'(we[CSR_MCAUSE]), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_value("t5_hold_valid", 32'(seq_if.redirect_valid), 32'h1);
      check_value("t5_hold_rpc",   seq_if.redirect_pc, 32'h8000_0200);
      present_trap(32'h3, 32'h8000_0300, 32'h0);
      seq_if.trap_req = (i == 1);
      tick();
    end
    seq_if.trap_req = 1'b0;
    finish_redirect();
    check_value("t5_idle",   32'(seq_if.busy), 32'h0);
    check_value("t5_mcause", csr_file[CSR_MCAUSE], 32'h0000_000B);
    check_value("t5_mstat",  csr_file[CSR_MSTATUS], 32'h0000_1880);
    tick();
    check_value("t5_stay_idle", 32'(seq_if.busy), 32'h0);

    // Soft reset during COMMIT
    present_trap(32'h4, 32'h8000_0010, 32'h0);
    tick();
    seq_if.trap_req = 1'b0;
    check_value("srst_busy_pre", 32'(seq_if.busy), 32'h1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check_value("srst_busy",  32'(seq_if.busy), 32'h0);
    check_value("srst_flush", 32'(seq_if.flush_req), 32'h0);

    // Asynchronous reset during REDIRECT
    present_trap(32'h1, 32'h8000_0020, 32'h0);
    tick();
    seq_if.trap_req = 1'b0;
    tick();
    check_value("t1_in_redirect", 32'(seq_if.redirect_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_value("t1_valid", 32'(seq_if.redirect_valid), 32'h0);
    check_value("t1_busy",  32'(seq_if.busy), 32'h0);
    check_value("t1_we",    32'(we), 32'h0);
    check_value("t1_rpc",   seq_if.redirect_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_value("t1_stay_idle", 32'(seq_if.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
